// File: rtl/div_ctrl_if.sv
// div_ctrl request/response bundle.
// Controller is the slave, the issuing core is the master.
interface div_ctrl_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic        dz_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  start_i, signed_i,
    input  dividend_i, divisor_i,
    output busy_o, done_o, dz_o,
    output hi_o, lo_o
  );

  modport master (
    output start_i, signed_i,
    output dividend_i, divisor_i,
    input  busy_o, done_o, dz_o,
    input  hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl.sv
// MIPS DIV/DIVU sequencer around an external
// DEPTH-stage magnitude divider pipeline.
module div_ctrl #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  div_ctrl_if.slave   bus,
  output logic [63:0] pipe_data_o,
  output logic [31:0] pipe_div_o,
  input  logic [63:0] pipe_res_i
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic [31:0]   div_q, div_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [63:0]   res_q, res_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          dz_q, dz_d;
  logic          done_q, done_d;

  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic          a_neg;
  logic          b_neg;

  assign a_neg = bus.signed_i & bus.dividend_i[31];
  assign b_neg = bus.signed_i & bus.divisor_i[31];
  assign mag_a = a_neg ? (~bus.dividend_i + 32'd1)
                       : bus.dividend_i;
  assign mag_b = b_neg ? (~bus.divisor_i + 32'd1)
                       : bus.divisor_i;

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.dz_o   = dz_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign pipe_data_o = data_q;
  assign pipe_div_o  = div_q;

  // Next-state and datapath updates for issue, wait and sign fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.divisor_i != 32'd0) begin
            state_d = RUN;
            cnt_d   = CW'(DEPTH);
            data_d  = {31'd0, mag_a, 1'b0};
            div_d   = mag_b;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end else begin
            hi_d   = bus.dividend_i;
            lo_d   = 32'hFFFF_FFFF;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          res_d   = pipe_res_i;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        lo_d    = qneg_q ? (~res_q[31:0] + 32'd1)
                         : res_q[31:0];
        hi_d    = rneg_q ? (~res_q[63:32] + 32'd1)
                         : res_q[63:32];
        dz_d    = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight op.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, meaning number of div_pipe stages between pipe_data_o and pipe_res_i (one cycle each).
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request pulse; sampled only in IDLE.
REQ-005 signed_i  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 dividend_i  input  32  dividend, sampled with start_i.
REQ-007 divisor_i  input  32  divisor, sampled with start_i.
REQ-008 busy_o  output  1  high whenever state is not IDLE.
REQ-009 pipe_data_o  output  64  working value into first pipeline stage.
REQ-010 pipe_div_o  output  32  divisor magnitude into first pipeline stage.
REQ-011 pipe_res_i  input  64  last-stage output: [63:32] remainder magnitude, [31:0] quotient magnitude.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 hi_o  output  32  signed/unsigned remainder (MIPS HI).
REQ-014 lo_o  output  32  signed/unsigned quotient (MIPS LO).
REQ-015 dz_o  output  1  divide-by-zero flag of last completed op.

Function
REQ-016 States IDLE, RUN, FIX; one operation in flight at a time.
REQ-017 IDLE & start_i & divisor_i!=0: next edge -> RUN, counter loaded with DEPTH, operands issued.
REQ-018 Issue: pipe_data_o <= {31'b0, |dividend|, 1'b0}; pipe_div_o <= |divisor|; both held until next issue.
REQ-019 Magnitude: if signed_i and operand bit31=1, two's complement; else operand unchanged (0x80000000 stays 0x80000000).
REQ-020 Latched at issue: qneg = signed_i & (dividend[31]^divisor[31]); rneg = signed_i & dividend[31].
REQ-021 RUN: counter decrements each edge; at edge where counter==0 (issue edge + DEPTH+1), pipe_res_i latched, -> FIX.
REQ-022 FIX: next edge -> IDLE; lo_o <= qneg ? -res[31:0] : res[31:0]; hi_o <= rneg ? -res[63:32] : res[63:32]; dz_o <= 0; done_o <= 1.
REQ-023 done_o high exactly one cycle (first IDLE cycle); latency issue edge to done_o high = DEPTH+2 cycles.
REQ-024 IDLE & start_i & divisor_i==0: pipeline not issued; next edge stays IDLE, hi_o <= dividend_i, lo_o <= 32'hFFFFFFFF, dz_o <= 1, done_o <= 1.
REQ-025 start_i while busy_o=1 ignored, no queuing, no effect on in-flight op.
REQ-026 start_i in done_o cycle accepted (state is IDLE).
REQ-027 hi_o, lo_o, dz_o hold until next completion.
REQ-028 All arithmetic modulo 2^32; no overflow flag (0x80000000 / -1 signed -> lo 0x80000000, hi 0).

Reset
REQ-029 rst_i low: state IDLE, counter 0, busy_o 0, done_o 0, dz_o 0, pipe_data_o 0, pipe_div_o 0, hi_o 0, lo_o 0, qneg/rneg 0.
REQ-030 Reset mid-operation aborts op immediately; no done_o after release; pipeline contents ignored.
REQ-031 First start_i after reset release accepted on the first edge with rst_i high.

Verification
REQ-032 Bench drives pipe_res_i from a DEPTH-stage restoring-divider model (shift-left-1 between stages) fed by pipe_data_o/pipe_div_o.
REQ-033 DIVU 100/7 -> done_o at issue+DEPTH+2, lo_o=14, hi_o=2, dz_o=0.
REQ-034 DIV -100/7 -> lo_o=0xFFFFFFF2, hi_o=0xFFFFFFFE; DIV 100/-7 -> lo_o=0xFFFFFFF2, hi_o=2.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; DIVU 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
REQ-036 Divisor 0, dividend 0x1234 -> done_o next cycle, dz_o=1, hi_o=0x1234, lo_o=0xFFFFFFFF, pipe_data_o unchanged.
REQ-037 start_i pulsed in RUN with other operands -> ignored, first result correct; rst_i low mid-RUN -> all outputs 0, no done_o; back-to-back start_i in done_o cycle -> second result DEPTH+2 cycles later.
